// File: rtl/eth_stat_pkg.sv
// Event index map shared by the statistics counter block and its users.
package eth_stat_pkg;

    localparam int unsigned TX_UNDERFLOW     = 0;
    localparam int unsigned TX_FIFO_OVERFLOW = 1;
    localparam int unsigned TX_FIFO_BAD      = 2;
    localparam int unsigned TX_FIFO_GOOD     = 3;
    localparam int unsigned RX_BAD_FRAME     = 4;
    localparam int unsigned RX_BAD_FCS       = 5;
    localparam int unsigned RX_FIFO_OVERFLOW = 6;
    localparam int unsigned RX_FIFO_BAD      = 7;
    localparam int unsigned RX_FIFO_GOOD     = 8;
    localparam int unsigned SPEED_CHANGE     = 9;

    localparam int unsigned NUM_STAT_EVENTS  = SPEED_CHANGE;

endpackage

// File: rtl/eth_stat_counter.sv
// Single statistics counter: clear-then-increment, saturating or wrapping.
module eth_stat_counter #(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned SATURATE      = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    input  logic                     clr,
    output logic [COUNTER_WIDTH-1:0] count
);

    logic [COUNTER_WIDTH-1:0] base;
    logic [COUNTER_WIDTH-1:0] next;

    // Clear applies first so a same-cycle event lands on the cleared value.
    always_comb begin
        base = clr ? '0 : count;
        next = base;
        if (inc) begin
            if ((SATURATE != 0) && (&base)) begin
                next = base;
            end else begin
                next = base + COUNTER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= next;
        end
    end

endmodule

// File: rtl/eth_mac_stat_counters.sv
// MAC statistics counters with snapshot bank, read/clear port and sticky interrupts.
module eth_mac_stat_counters
    import eth_stat_pkg::*;
#(
    parameter int unsigned NUM_EVENTS      = NUM_STAT_EVENTS,
    parameter int unsigned COUNTER_WIDTH   = 32,
    parameter int unsigned SATURATE        = 1,
    parameter int unsigned SNAPSHOT_ENABLE = 1,
    localparam int unsigned AW             = $clog2(NUM_EVENTS + 1)
) (
    input  logic                     logic_clk,
    input  logic                     logic_rst,
    input  logic [NUM_EVENTS-1:0]    event_i,
    input  logic [1:0]               speed_i,
    input  logic                     snapshot_i,
    input  logic                     rd_v_i,
    input  logic [AW-1:0]            rd_addr_i,
    input  logic                     rd_clear_i,
    output logic                     rd_ready_o,
    output logic                     rd_v_o,
    output logic [COUNTER_WIDTH-1:0] rd_data_o,
    input  logic                     rd_yumi_i,
    input  logic [NUM_EVENTS:0]      irq_mask_i,
    input  logic [NUM_EVENTS:0]      irq_clear_i,
    output logic [NUM_EVENTS:0]      irq_pending_o,
    output logic                     irq_o,
    output logic                     speed_change_o
);

    localparam int unsigned NC = NUM_EVENTS + 1;

    logic [NC-1:0]            inc;
    logic [NC-1:0]            clr;
    logic [COUNTER_WIDTH-1:0] live [NC];
    logic [COUNTER_WIDTH-1:0] snap [NC];
    logic [COUNTER_WIDTH-1:0] rd_sel;
    logic [1:0]               speed_q;
    logic                     speed_valid;
    logic                     speed_evt;
    logic                     hs;

    // speed_valid suppresses a bogus change against the reset value of speed_q.
    assign speed_evt  = speed_valid & (speed_i != speed_q);
    assign inc        = {speed_evt, event_i};
    assign rd_ready_o = logic_rst | ~rd_v_o | rd_yumi_i;
    assign hs         = rd_v_i & rd_ready_o & ~logic_rst;

    // Out-of-range addresses match no index: they read 0 and clear nothing.
    always_comb begin
        rd_sel = '0;
        clr    = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (rd_addr_i == AW'(i)) begin
                rd_sel = (SNAPSHOT_ENABLE != 0) ? snap[i] : live[i];
                clr[i] = hs & rd_clear_i;
            end
        end
    end

    for (genvar g = 0; g < NC; g++) begin : g_cnt
        eth_stat_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .SATURATE      (SATURATE)
        ) u_cnt (
            .clk   (logic_clk),
            .rst   (logic_rst),
            .inc   (inc[g]),
            .clr   (clr[g]),
            .count (live[g])
        );
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            for (int unsigned i = 0; i < NC; i++) snap[i] <= '0;
        end else if (snapshot_i) begin
            for (int unsigned i = 0; i < NC; i++) snap[i] <= live[i];
        end
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            rd_v_o    <= 1'b0;
            rd_data_o <= '0;
        end else if (hs) begin
            rd_v_o    <= 1'b1;
            rd_data_o <= rd_sel;
        end else if (rd_yumi_i) begin
            rd_v_o    <= 1'b0;
        end
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            speed_q        <= '0;
            speed_valid    <= 1'b0;
            speed_change_o <= 1'b0;
        end else begin
            speed_q        <= speed_i;
            speed_valid    <= 1'b1;
            speed_change_o <= speed_evt;
        end
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            irq_pending_o <= '0;
            irq_o         <= 1'b0;
        end else begin
            irq_pending_o <= inc | (irq_pending_o & ~irq_clear_i);
            irq_o         <= |(irq_pending_o & irq_mask_i);
        end
    end

endmodule

// File: tb/tb_eth_mac_stat_counters.sv
// Bench for eth_mac_stat_counters: four configurations share one stimulus stream.
module tb_eth_mac_stat_counters;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [8:0] ev;
    logic [1:0] spd;
    logic       snp;
    logic       rdv;
    logic [3:0] addr;
    logic       clr;
    logic       yumi;
    logic [9:0] mask;
    logic [9:0] iclr;

    logic [3:0]  rv, rr, irq, sc;
    logic [9:0]  pend [4];
    logic [31:0] d_live, d_snap;
    logic [3:0]  d_sat, d_wrap;

    eth_mac_stat_counters #(.NUM_EVENTS(9), .COUNTER_WIDTH(32), .SATURATE(1), .SNAPSHOT_ENABLE(0)) u_live (
        .logic_clk(clk), .logic_rst(rst), .event_i(ev), .speed_i(spd), .snapshot_i(snp),
        .rd_v_i(rdv), .rd_addr_i(addr), .rd_clear_i(clr), .rd_ready_o(rr[0]), .rd_v_o(rv[0]),
        .rd_data_o(d_live), .rd_yumi_i(yumi), .irq_mask_i(mask), .irq_clear_i(iclr),
        .irq_pending_o(pend[0]), .irq_o(irq[0]), .speed_change_o(sc[0]));

    eth_mac_stat_counters #(.NUM_EVENTS(9), .COUNTER_WIDTH(4), .SATURATE(1), .SNAPSHOT_ENABLE(0)) u_sat (
        .logic_clk(clk), .logic_rst(rst), .event_i(ev), .speed_i(spd), .snapshot_i(snp),
        .rd_v_i(rdv), .rd_addr_i(addr), .rd_clear_i(clr), .rd_ready_o(rr[1]), .rd_v_o(rv[1]),
        .rd_data_o(d_sat), .rd_yumi_i(yumi), .irq_mask_i(mask), .irq_clear_i(iclr),
        .irq_pending_o(pend[1]), .irq_o(irq[1]), .speed_change_o(sc[1]));

    eth_mac_stat_counters #(.NUM_EVENTS(9), .COUNTER_WIDTH(4), .SATURATE(0), .SNAPSHOT_ENABLE(0)) u_wrap (
        .logic_clk(clk), .logic_rst(rst), .event_i(ev), .speed_i(spd), .snapshot_i(snp),
        .rd_v_i(rdv), .rd_addr_i(addr), .rd_clear_i(clr), .rd_ready_o(rr[2]), .rd_v_o(rv[2]),
        .rd_data_o(d_wrap), .rd_yumi_i(yumi), .irq_mask_i(mask), .irq_clear_i(iclr),
        .irq_pending_o(pend[2]), .irq_o(irq[2]), .speed_change_o(sc[2]));

    eth_mac_stat_counters #(.NUM_EVENTS(9), .COUNTER_WIDTH(32), .SATURATE(1), .SNAPSHOT_ENABLE(1)) u_snap (
        .logic_clk(clk), .logic_rst(rst), .event_i(ev), .speed_i(spd), .snapshot_i(snp),
        .rd_v_i(rdv), .rd_addr_i(addr), .rd_clear_i(clr), .rd_ready_o(rr[3]), .rd_v_o(rv[3]),
        .rd_data_o(d_snap), .rd_yumi_i(yumi), .irq_mask_i(mask), .irq_clear_i(iclr),
        .irq_pending_o(pend[3]), .irq_o(irq[3]), .speed_change_o(sc[3]));

    int checks = 0;
    int errors = 0;

    // Reference model: per-configuration counter values as plain integers.
    int unsigned     cfg_w    [4] = '{32, 4, 4, 32};
    bit              cfg_sat  [4] = '{1, 1, 0, 1};
    bit              cfg_snap [4] = '{0, 0, 0, 1};
    longint unsigned m_live [4][10];
    longint unsigned m_snap [4][10];
    longint unsigned m_rdd  [4];
    bit              m_rdv, m_irq, m_sc, m_sv;
    bit [9:0]        m_pend;
    bit [1:0]        m_spd;

    function automatic logic [63:0] dout(input int c);
        case (c)
            0: return 64'(d_live);
            1: return 64'(d_sat);
            2: return 64'(d_wrap);
            default: return 64'(d_snap);
        endcase
    endfunction

    function automatic longint unsigned bump(input longint unsigned v, input int c);
        longint unsigned maxv = (64'd1 << cfg_w[c]) - 1;
        if (v == maxv) return cfg_sat[c] ? maxv : 64'd0;
        return v + 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit [9:0] e;
        bit hs;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_rdd[c] = 0;
                for (int i = 0; i < 10; i++) begin
                    m_live[c][i] = 0;
                    m_snap[c][i] = 0;
                end
            end
            m_rdv = 0; m_irq = 0; m_sc = 0; m_sv = 0; m_pend = '0; m_spd = '0;
            return;
        end
        e  = {m_sv && (spd != m_spd), ev};
        hs = rdv && (!m_rdv || yumi);
        for (int c = 0; c < 4; c++) begin
            if (hs) begin
                if (addr <= 9) m_rdd[c] = cfg_snap[c] ? m_snap[c][addr] : m_live[c][addr];
                else           m_rdd[c] = 0;
            end
            for (int i = 0; i < 10; i++) begin
                if (snp) m_snap[c][i] = m_live[c][i];
                if (hs && clr && addr == 4'(i)) m_live[c][i] = 0;
                if (e[i]) m_live[c][i] = bump(m_live[c][i], c);
            end
        end
        m_rdv  = hs ? 1'b1 : (yumi ? 1'b0 : m_rdv);
        m_irq  = |(m_pend & mask);
        m_pend = e | (m_pend & ~iclr);
        m_sc   = e[9];
        m_spd  = spd;
        m_sv   = 1'b1;
    endtask

    task automatic cycle();
        #1;
        for (int c = 0; c < 4; c++)
            chk($sformatf("ready[%0d]", c), 64'(rr[c]), 64'(rst || !m_rdv || yumi));
        model_step();
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rd_v[%0d]", c), 64'(rv[c]), 64'(m_rdv));
            chk($sformatf("rd_data[%0d]", c), dout(c), m_rdd[c]);
            chk($sformatf("pending[%0d]", c), 64'(pend[c]), 64'(m_pend));
            chk($sformatf("irq[%0d]", c), 64'(irq[c]), 64'(m_irq));
            chk($sformatf("spd_chg[%0d]", c), 64'(sc[c]), 64'(m_sc));
        end
    endtask

    task automatic set_idle();
        rst = 0; ev = '0; snp = 0; rdv = 0; addr = '0; clr = 0; yumi = 0; iclr = '0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1; ev = '1; rdv = 1; clr = 1; snp = 1; yumi = 1;
        cycle();
        cycle();
        set_idle();
    endtask

    typedef struct {
        logic [8:0]  ev;
        logic        rdv;
        logic [3:0]  addr;
        logic        clr;
        logic        yumi;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;

    function automatic vec_t mk(input logic [8:0] e, input logic v, input logic [3:0] a,
                                input logic c, input logic y, input logic xv, input logic [31:0] xd);
        vec_t r;
        r.ev = e; r.rdv = v; r.addr = a; r.clr = c; r.yumi = y; r.exp_v = xv; r.exp_d = xd;
        return r;
    endfunction

    vec_t tbl [19];

    initial begin
        tbl[0]  = mk(9'h001, 0, 0,  0, 0, 0, 0);
        tbl[1]  = mk(9'h001, 0, 0,  0, 0, 0, 0);
        tbl[2]  = mk(9'h001, 0, 0,  0, 0, 0, 0);
        tbl[3]  = mk(9'h001, 0, 0,  0, 0, 0, 0);
        tbl[4]  = mk(9'h001, 0, 0,  0, 0, 0, 0);
        tbl[5]  = mk(9'h000, 1, 0,  0, 0, 1, 5);
        tbl[6]  = mk(9'h000, 0, 0,  0, 1, 0, 0);
        tbl[7]  = mk(9'h000, 1, 0,  0, 0, 1, 5);
        tbl[8]  = mk(9'h000, 1, 0,  0, 1, 1, 5);
        tbl[9]  = mk(9'h000, 0, 0,  0, 1, 0, 0);
        tbl[10] = mk(9'h004, 0, 0,  0, 0, 0, 0);
        tbl[11] = mk(9'h004, 0, 0,  0, 0, 0, 0);
        tbl[12] = mk(9'h004, 0, 0,  0, 0, 0, 0);
        tbl[13] = mk(9'h004, 1, 2,  1, 0, 1, 3);
        tbl[14] = mk(9'h000, 0, 0,  0, 1, 0, 0);
        tbl[15] = mk(9'h000, 1, 2,  0, 0, 1, 1);
        tbl[16] = mk(9'h000, 1, 12, 1, 1, 1, 0);
        tbl[17] = mk(9'h000, 1, 0,  0, 1, 1, 5);
        tbl[18] = mk(9'h000, 0, 0,  0, 1, 0, 0);

        spd = 2'b00; mask = '0;
        model_step();
        do_reset();
        chk("reset_rd_v", 64'(rv[0]), 0);
        chk("reset_pending", 64'(pend[0]), 0);
        chk("reset_rd_data", 64'(d_live), 0);

        // count, read twice, read-clear with coincident event, out-of-range read
        for (int k = 0; k < 19; k++) begin
            ev = tbl[k].ev; rdv = tbl[k].rdv; addr = tbl[k].addr;
            clr = tbl[k].clr; yumi = tbl[k].yumi;
            cycle();
            chk($sformatf("tbl%0d_v", k), 64'(rv[0]), 64'(tbl[k].exp_v));
            if (tbl[k].exp_v) chk($sformatf("tbl%0d_d", k), 64'(d_live), 64'(tbl[k].exp_d));
        end

        // saturate vs wrap with 4-bit counters
        do_reset();
        ev = 9'h002;
        repeat (20) cycle();
        ev = '0; rdv = 1; addr = 1;
        cycle();
        chk("sat_20", 64'(d_sat), 15);
        chk("wrap_20", 64'(d_wrap), 4);
        chk("live_20", 64'(d_live), 20);
        set_idle(); yumi = 1;
        cycle();

        // speed change pulse, counter and interrupt
        spd = 2'b10;
        do_reset();
        cycle();
        chk("no_pulse_after_rst", 64'(sc[0]), 0);
        cycle();
        mask = 10'h200; spd = 2'b01;
        cycle();
        chk("spd_pulse", 64'(sc[0]), 1);
        chk("spd_pending", 64'(pend[0][9]), 1);
        cycle();
        chk("spd_pulse_end", 64'(sc[0]), 0);
        chk("irq_rise", 64'(irq[0]), 1);
        iclr = 10'h200;
        cycle();
        chk("irq_clr_pending", 64'(pend[0][9]), 0);
        iclr = '0;
        cycle();
        chk("irq_fall", 64'(irq[0]), 0);
        rdv = 1; addr = 9;
        cycle();
        chk("spd_count", 64'(d_live), 1);
        set_idle(); yumi = 1; mask = '0;
        cycle();

        // snapshot bank, including snapshot coincident with a read
        do_reset();
        ev = 9'h008;
        repeat (3) cycle();
        ev = '0; snp = 1;
        cycle();
        snp = 0; ev = 9'h008;
        repeat (4) cycle();
        ev = '0; rdv = 1; addr = 3; snp = 1;
        cycle();
        chk("snap_first", 64'(d_snap), 3);
        set_idle(); yumi = 1;
        cycle();
        yumi = 0; rdv = 1; addr = 3;
        cycle();
        chk("snap_second", 64'(d_snap), 7);
        set_idle(); yumi = 1;
        cycle();

        // held response, then reset mid-hold drops it
        do_reset();
        ev = 9'h001;
        repeat (2) cycle();
        ev = '0; rdv = 1; addr = 0;
        cycle();
        chk("hold_first", 64'(d_live), 2);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("hold%0d_ready", k), 64'(rr[0]), 0);
            chk($sformatf("hold%0d_data", k), 64'(d_live), 2);
            chk($sformatf("hold%0d_v", k), 64'(rv[0]), 1);
        end
        rst = 1;
        cycle();
        chk("rst_drop_v", 64'(rv[0]), 0);
        set_idle();
        rdv = 1; yumi = 1;
        for (int a = 0; a < 10; a++) begin
            addr = 4'(a);
            cycle();
            for (int c = 0; c < 4; c++) chk($sformatf("zero%0d_%0d", a, c), dout(c), 0);
        end
        set_idle();

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rst  = ($urandom_range(0, 99) == 0);
            ev   = 9'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) spd = 2'($urandom_range(0, 3));
            snp  = ($urandom_range(0, 7) == 0);
            rdv  = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 15));
            clr  = ($urandom_range(0, 3) == 0);
            yumi = 1'($urandom_range(0, 1));
            mask = 10'($urandom);
            iclr = 10'($urandom & $urandom & $urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
